saturate_u8: RTL and testbench
==============================

# saturate_u8

Unsigned clamp stage for the brightness datapath. It takes wide per-channel products, already right-shifted by 3 (the ×level/8 gain), and limits each to the 8-bit pixel range. It sits between the brightness multipliers and the pixel output, one instance per R/G/B channel. Output is registered, with a valid flag, a per-sample saturation flag and a running count of clipped samples for tuning and debug.

## Interface
Parameters:
- IN_W, default 10: input sample width, unsigned.
- OUT_W, default 8: output sample width, unsigned. Must satisfy OUT_W ≤ IN_W.
- CNT_W, default 16: width of the clipped-sample counter.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies din this cycle.
- din  in  IN_W  unsigned sample (product[12:3] in brightness).
- cnt_clr  in  1  synchronous clear of sat_count.
- dout  out  OUT_W  clamped sample.
- out_valid  out  1  dout/sat valid.
- sat  out  1  high when the sample in dout was clipped.
- sat_count  out  CNT_W  number of clipped valid samples.

## Operation
- MAX = 2^OUT_W − 1, which is 255 at default parameters.
- Clamp rule: if din > MAX, the result is MAX and sat_next = 1. Otherwise the result is din[OUT_W−1:0] and sat_next = 0.
- din == MAX passes through unchanged with sat_next = 0.
- No signed interpretation. din is always non-negative.
- Register update every cycle, not only when in_valid = 1:
  - dout ← result
  - sat ← sat_next & in_valid
  - out_valid ← in_valid
- When in_valid = 0, dout still takes the clamped din. Consumers must ignore dout while out_valid = 0.
- sat_count update:
  - Increments by 1 on each cycle with in_valid & sat_next.
  - Saturates at 2^CNT_W − 1; it never wraps.
  - cnt_clr has priority over increment. If cnt_clr and a clipped sample arrive together, the result is 0.
- Reset:
  - rst = 1 forces dout = 0, out_valid = 0, sat = 0 and sat_count = 0 at the next edge.
  - rst overrides in_valid and cnt_clr. A sample presented during reset is dropped.
- No backpressure. The block accepts a sample every cycle.

## Timing
- Latency: exactly 1 clock from din/in_valid to dout/out_valid/sat.
- sat_count reflects a clipped sample in the same cycle its out_valid/sat rise.
- Throughput: 1 sample per clock.
- After rst deasserts, the first valid input appears at the output one cycle later.
- Reset mid-stream: out_valid is low in the cycle after the reset edge. Data already captured is lost, not delayed.
- Combinational path is one comparator plus a mux. It must fit a single pixel-clock cycle.

## Structure
- Shared package holds:
  - pixel width constant PIX_W = 8
  - brightness product width PROD_W = 13 and its shift amount = 3
  - default CNT_W
- Sub-module: sat_clamp, purely combinational. Parameters are IN_W and OUT_W; ports are din, dout, over.
- saturate_u8 wraps sat_clamp with the output registers and the counter.
- The brightness block instantiates three saturate_u8, one each for R, G and B.

## Test plan
- Pass-through at default parameters, no reset pending:
  - in_valid = 1, din = 200 → next cycle dout = 200, sat = 0, out_valid = 1.
  - din = 255 → dout = 255, sat = 0.
- Clip at the boundary:
  - din = 256 → dout = 255, sat = 1, sat_count = 1.
  - Then din = 1023 → dout = 255, sat = 1, sat_count = 2.
- Brightness worst case: R = 255, level = 15, product 3825, din = 478 → dout = 255, sat = 1. Level = 8 gives din = 255 → dout = 255, sat = 0.
- Valid gating:
  - in_valid = 0 with din = 600 → out_valid = 0, sat = 0, sat_count unchanged.
  - cnt_clr = 1 together with a clipped sample → sat_count = 0.
- Counter saturation: CNT_W = 4 with 20 consecutive clipped samples → sat_count stops at 15.
- Reset mid-stream: stream din = 300 for several cycles, then assert rst for 1 cycle → next cycle dout = 0, out_valid = 0, sat = 0, sat_count = 0. Streaming resumes one cycle after rst deasserts.

Source files
------------

// File: rtl/saturate_u8_pkg.sv
// Shared constants for the brightness datapath clamp stage.
package saturate_u8_pkg;
  localparam int unsigned PIX_W         = 8;
  localparam int unsigned PROD_W        = 13;
  localparam int unsigned PROD_SHIFT    = 3;
  localparam int unsigned SAT_CNT_W_DEF = 16;
endpackage

// File: rtl/saturate_u8_clamp.sv
// Purely combinational unsigned clamp of an IN_W sample to OUT_W bits.
module sat_clamp #(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             over
);
  logic [IN_W-1:0] max_val;

  // Built bitwise so the IN_W == OUT_W case needs no zero-width replication.
  always_comb begin
    max_val              = '0;
    max_val[OUT_W-1:0]   = '1;
  end

  always_comb begin
    over = (din > max_val);
    dout = over ? '1 : din[OUT_W-1:0];
  end
endmodule

// File: rtl/saturate_u8.sv
// Registered unsigned clamp with valid, per-sample clip flag and saturating clip counter.
module saturate_u8
  import saturate_u8_pkg::*;
#(
  parameter int unsigned IN_W  = 10,
  parameter int unsigned OUT_W = PIX_W,
  parameter int unsigned CNT_W = SAT_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  din,
  input  logic             cnt_clr,
  output logic [OUT_W-1:0] dout,
  output logic             out_valid,
  output logic             sat,
  output logic [CNT_W-1:0] sat_count
);
  logic [OUT_W-1:0] clamped;
  logic             over;

  sat_clamp #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_clamp (
    .din  (din),
    .dout (clamped),
    .over (over)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      out_valid <= 1'b0;
      sat       <= 1'b0;
    end else begin
      dout      <= clamped;
      out_valid <= in_valid;
      sat       <= over & in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sat_count <= '0;
    end else if (in_valid && over && (sat_count != '1)) begin
      sat_count <= sat_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_saturate_u8.sv
// Self-checking bench for saturate_u8: directed table, corner sequences, random vs model.
module tb_saturate_u8;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [9:0] din = '0;
  logic       cnt_clr = 1'b0;

  logic [7:0]  dout_a, dout_b;
  logic        valid_a, valid_b, sat_a, sat_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int  m_dout = 0;
  bit  m_valid = 0, m_sat = 0;
  int  m_cnt_a = 0, m_cnt_b = 0;

  always #5 clk = ~clk;

  saturate_u8 #(.IN_W(10), .OUT_W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_a), .out_valid(valid_a), .sat(sat_a), .sat_count(cnt_a)
  );

  saturate_u8 #(.IN_W(10), .OUT_W(8), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .din(din), .cnt_clr(cnt_clr),
    .dout(dout_b), .out_valid(valid_b), .sat(sat_b), .sat_count(cnt_b)
  );

  typedef struct {
    bit v; int d; bit c; bit r;
    int e_dout; bit e_sat; bit e_valid; int e_cnt;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model, sample #1 after the edge.
  task automatic apply(input bit v, input int d, input bit c, input bit r);
    bit clip;
    in_valid = v;
    din      = d[9:0];
    cnt_clr  = c;
    rst      = r;
    @(posedge clk);
    clip = (d > 255);
    if (r) begin
      m_dout = 0; m_valid = 0; m_sat = 0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      m_dout  = clip ? 255 : d;
      m_valid = v;
      m_sat   = v && clip;
      if (c) begin
        m_cnt_a = 0; m_cnt_b = 0;
      end else if (v && clip) begin
        if (m_cnt_a < 65535) m_cnt_a++;
        if (m_cnt_b < 15)    m_cnt_b++;
      end
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".dout_a"},  int'(dout_a),  m_dout);
    check({tag, ".dout_b"},  int'(dout_b),  m_dout);
    check({tag, ".valid_a"}, int'(valid_a), int'(m_valid));
    check({tag, ".valid_b"}, int'(valid_b), int'(m_valid));
    check({tag, ".sat_a"},   int'(sat_a),   int'(m_sat));
    check({tag, ".sat_b"},   int'(sat_b),   int'(m_sat));
    check({tag, ".cnt_a"},   int'(cnt_a),   m_cnt_a);
    check({tag, ".cnt_b"},   int'(cnt_b),   m_cnt_b);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{0,   0, 0, 1,   0, 0, 0, 0};  // reset
    vecs[1] = '{1, 200, 0, 0, 200, 0, 1, 0};  // pass-through
    vecs[2] = '{1, 255, 0, 0, 255, 0, 1, 0};  // exactly MAX
    vecs[3] = '{1, 256, 0, 0, 255, 1, 1, 1};  // first clip
    vecs[4] = '{1,1023, 0, 0, 255, 1, 1, 2};  // max input
    vecs[5] = '{1, 478, 0, 0, 255, 1, 1, 3};  // 3825 >> 3
    vecs[6] = '{0, 600, 0, 0, 255, 0, 0, 3};  // invalid: no sat, no count
    vecs[7] = '{1, 300, 1, 0, 255, 1, 1, 0};  // clear beats increment
    vecs[8] = '{1,   0, 0, 0,   0, 0, 1, 0};

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i].v, vecs[i].d, vecs[i].c, vecs[i].r);
      check($sformatf("vec%0d.dout", i),  int'(dout_a),  vecs[i].e_dout);
      check($sformatf("vec%0d.sat", i),   int'(sat_a),   int'(vecs[i].e_sat));
      check($sformatf("vec%0d.valid", i), int'(valid_a), int'(vecs[i].e_valid));
      check($sformatf("vec%0d.cnt_a", i), int'(cnt_a),   vecs[i].e_cnt);
      check($sformatf("vec%0d.cnt_b", i), int'(cnt_b),   vecs[i].e_cnt);
    end

    // Counter saturation: 20 clipped samples from a cleared counter.
    apply(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) apply(1, 300 + i, 0, 0);
    check("sat20.cnt_b", int'(cnt_b), 15);
    check("sat20.cnt_a", int'(cnt_a), 20);
    apply(1, 700, 0, 0);
    check("sat21.cnt_b_hold", int'(cnt_b), 15);

    // Reset mid-stream, then resume.
    for (int i = 0; i < 4; i++) apply(1, 300, 0, 0);
    apply(1, 300, 0, 1);
    check("midrst.dout",  int'(dout_a),  0);
    check("midrst.valid", int'(valid_a), 0);
    check("midrst.sat",   int'(sat_a),   0);
    check("midrst.cnt",   int'(cnt_a),   0);
    apply(1, 300, 0, 0);
    check("resume.dout",  int'(dout_a),  255);
    check("resume.valid", int'(valid_a), 1);
    check("resume.sat",   int'(sat_a),   1);
    check("resume.cnt",   int'(cnt_a),   1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bit v, c, r;
      int d;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 31) == 0);
      r = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 3))
        0: d = $urandom_range(250, 260);
        1: d = $urandom_range(0, 255);
        default: d = $urandom_range(0, 1023);
      endcase
      apply(v, d, c, r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
